// File: rtl/svf_voice_if.sv
// Voice-side bundle of the time-multiplexed state-variable filter:
// per-voice audio and coefficients in, per-voice filter taps and frame status out.
interface svf_voice_if #(
  parameter int NUM_VOICES = 3
);
  logic                     sample_valid;
  logic [NUM_VOICES*8-1:0]  voice_in;
  logic [NUM_VOICES*11-1:0] voice_alpha1;
  logic [NUM_VOICES*2-1:0]  voice_alpha2;
  logic [NUM_VOICES*8-1:0]  voice_hp;
  logic [NUM_VOICES*8-1:0]  voice_bp;
  logic [NUM_VOICES*8-1:0]  voice_lp;
  logic                     busy;
  logic                     frame_done;
  logic                     overrun;

  modport master (
    output sample_valid, voice_in, voice_alpha1, voice_alpha2,
    input  voice_hp, voice_bp, voice_lp, busy, frame_done, overrun
  );

  modport slave (
    input  sample_valid, voice_in, voice_alpha1, voice_alpha2,
    output voice_hp, voice_bp, voice_lp, busy, frame_done, overrun
  );
endinterface

// File: rtl/svf_voice_scheduler.sv
// Chamberlin SVF shared across voices: one 16x12 multiplier, per-voice
// Q8.8 bp/lp state, three cycles (hp, bp, lp) per voice per frame.
module svf_voice_scheduler #(
  parameter int NUM_VOICES = 3
) (
  input logic       clk,
  input logic       rst,
  svf_voice_if.slave bus
);
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HP   = 2'd1;
  localparam logic [1:0] S_BP   = 2'd2;
  localparam logic [1:0] S_LP   = 2'd3;

  logic [1:0]          state;
  logic [VW-1:0]       vi;
  logic signed [15:0]  bp_st [NUM_VOICES];
  logic signed [15:0]  lp_st [NUM_VOICES];
  logic signed [7:0]   in_s  [NUM_VOICES];
  logic [10:0]         a1_s  [NUM_VOICES];
  logic [1:0]          a2_s  [NUM_VOICES];
  logic signed [15:0]  hp_r;
  logic signed [15:0]  bpn_r;
  logic [NUM_VOICES*8-1:0] hp_o;
  logic [NUM_VOICES*8-1:0] bp_o;
  logic [NUM_VOICES*8-1:0] lp_o;
  logic                busy_r;
  logic                done_r;
  logic                ovr_r;

  function automatic logic signed [17:0] ext18(input logic signed [15:0] x);
    return x;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [17:0] x);
    if (x > 18'sd32767)
      return 16'sh7fff;
    else if (x < -18'sd32768)
      return 16'sh8000;
    else
      return x[15:0];
  endfunction

  logic signed [7:0]  cur_in;
  logic signed [15:0] cur_bp;
  logic signed [15:0] cur_lp;
  logic [10:0]        cur_a1;
  logic [1:0]         cur_a2;
  logic signed [17:0] qmul;
  logic signed [17:0] hp_sum;
  logic signed [15:0] mul_a;
  logic signed [27:0] prod;
  logic signed [15:0] f;
  logic signed [17:0] bp_sum;
  logic signed [17:0] lp_sum;

  // The single multiplier: its operand follows the step being executed.
  always_comb begin
    cur_in = in_s[vi];
    cur_bp = bp_st[vi];
    cur_lp = lp_st[vi];
    cur_a1 = a1_s[vi];
    cur_a2 = a2_s[vi];
    qmul   = '0;
    if (cur_a2[1]) qmul = qmul + ext18(cur_bp >>> 1);
    if (cur_a2[0]) qmul = qmul + ext18(cur_bp >>> 2);
    hp_sum = ext18({cur_in, 8'h00}) - ext18(cur_lp) - qmul;
    mul_a  = (state == S_BP) ? hp_r : bpn_r;
    prod   = mul_a * $signed({1'b0, cur_a1});
    f      = 16'(prod >>> 14);
    bp_sum = ext18(cur_bp) + ext18(f);
    lp_sum = ext18(cur_lp) + ext18(f);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      vi     <= '0;
      hp_r   <= '0;
      bpn_r  <= '0;
      hp_o   <= '0;
      bp_o   <= '0;
      lp_o   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      ovr_r  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        bp_st[i] <= '0;
        lp_st[i] <= '0;
        in_s[i]  <= '0;
        a1_s[i]  <= '0;
        a2_s[i]  <= '0;
      end
    end else begin
      done_r <= 1'b0;
      ovr_r  <= bus.sample_valid && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (bus.sample_valid) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              in_s[i] <= bus.voice_in[8*i +: 8];
              a1_s[i] <= bus.voice_alpha1[11*i +: 11];
              a2_s[i] <= bus.voice_alpha2[2*i +: 2];
            end
            busy_r <= 1'b1;
            vi     <= '0;
            state  <= S_HP;
          end
        end
        S_HP: begin
          hp_r  <= sat16(hp_sum);
          state <= S_BP;
        end
        S_BP: begin
          bpn_r <= sat16(bp_sum);
          state <= S_LP;
        end
        default: begin
          bp_st[vi] <= bpn_r;
          lp_st[vi] <= sat16(lp_sum);
          hp_o[8*int'(vi) +: 8] <= hp_r[15:8];
          bp_o[8*int'(vi) +: 8] <= bpn_r[15:8];
          lp_o[8*int'(vi) +: 8] <= sat16(lp_sum) >>> 8;
          if (vi == LAST) begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else begin
            vi    <= vi + VW'(1);
            state <= S_HP;
          end
        end
      endcase
    end
  end

  assign bus.voice_hp   = hp_o;
  assign bus.voice_bp   = bp_o;
  assign bus.voice_lp   = lp_o;
  assign bus.busy       = busy_r;
  assign bus.frame_done = done_r;
  assign bus.overrun    = ovr_r;
endmodule

// File: tb/tb_svf_voice_scheduler.sv
// Bench for svf_voice_scheduler: integer frame model with edge-accurate
// output timing, per-cycle compare, plus directed literal expectations.
module tb_svf_voice_scheduler;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nfail = 0;

  svf_voice_if #(.NUM_VOICES(N)) bus ();

  svf_voice_scheduler #(.NUM_VOICES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_bp [N];
  int m_lp [N];
  int p_hp [N];
  int p_bp [N];
  int p_lp [N];
  int e_hp [N];
  int e_bp [N];
  int e_lp [N];
  bit m_busy = 0;
  bit e_done = 0;
  bit e_ovr  = 0;
  bit mv     = 0;
  int k      = 0;

  function automatic int sat(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_frame();
    for (int v = 0; v < N; v++) begin
      int in, a1, a2, hp, bp, lp, q;
      in = int'($signed(bus.voice_in[8*v +: 8]));
      a1 = int'(bus.voice_alpha1[11*v +: 11]);
      a2 = int'(bus.voice_alpha2[2*v +: 2]);
      q  = 0;
      if (a2[1]) q += m_bp[v] >>> 1;
      if (a2[0]) q += m_bp[v] >>> 2;
      hp = sat(in * 256 - m_lp[v] - q);
      bp = sat(m_bp[v] + ((hp * a1) >>> 14));
      lp = sat(m_lp[v] + ((bp * a1) >>> 14));
      m_bp[v] = bp;
      m_lp[v] = lp;
      p_hp[v] = hp >>> 8;
      p_bp[v] = bp >>> 8;
      p_lp[v] = lp >>> 8;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      e_done = 0;
      e_ovr  = 0;
      if (rst) begin
        for (int v = 0; v < N; v++) begin
          m_bp[v] = 0; m_lp[v] = 0;
          e_hp[v] = 0; e_bp[v] = 0; e_lp[v] = 0;
        end
        m_busy = 0;
        mv     = 1;
      end else if (m_busy) begin
        k++;
        e_ovr = bus.sample_valid;
        if (k % 3 == 0) begin
          e_hp[k/3-1] = p_hp[k/3-1];
          e_bp[k/3-1] = p_bp[k/3-1];
          e_lp[k/3-1] = p_lp[k/3-1];
        end
        if (k == 3 * N) begin
          e_done = 1;
          m_busy = 0;
        end
      end else if (bus.sample_valid) begin
        model_frame();
        m_busy = 1;
        k = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (mv) begin
        logic [N*8-1:0] xh, xb, xl;
        for (int v = 0; v < N; v++) begin
          xh[8*v +: 8] = 8'(e_hp[v]);
          xb[8*v +: 8] = 8'(e_bp[v]);
          xl[8*v +: 8] = 8'(e_lp[v]);
        end
        nchk++;
        if ({bus.busy, bus.frame_done, bus.overrun,
             bus.voice_hp, bus.voice_bp, bus.voice_lp} !==
            {m_busy, e_done, e_ovr, xh, xb, xl}) begin
          nfail++;
          $display("FAIL cycle_model t=%0t got b/d/o=%b%b%b hp=%h bp=%h lp=%h need %b%b%b hp=%h bp=%h lp=%h",
                   $time, bus.busy, bus.frame_done, bus.overrun,
                   bus.voice_hp, bus.voice_bp, bus.voice_lp,
                   m_busy, e_done, e_ovr, xh, xb, xl);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int hp_of(input int v);
    return int'($signed(bus.voice_hp[8*v +: 8]));
  endfunction
  function automatic int bp_of(input int v);
    return int'($signed(bus.voice_bp[8*v +: 8]));
  endfunction
  function automatic int lp_of(input int v);
    return int'($signed(bus.voice_lp[8*v +: 8]));
  endfunction

  task automatic set_voice(input int v, input int in, input int a1, input int a2);
    bus.voice_in[8*v +: 8]      = 8'(in);
    bus.voice_alpha1[11*v +: 11] = 11'(a1);
    bus.voice_alpha2[2*v +: 2]  = 2'(a2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse();
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.frame_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.frame_done) begin
      nchk++;
      nfail++;
      $display("FAIL wait_done: got frame_done=0 expected 1 within 60 cycles");
    end
  endtask

  task automatic scen1_config();
    set_voice(0, 64, 2047, 0);
    set_voice(1, 0, 0, 0);
    set_voice(2, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.sample_valid = 1'b0;
    bus.voice_in     = '0;
    bus.voice_alpha1 = '0;
    bus.voice_alpha2 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_hp", int'(bus.voice_hp), 0);
    rst = 1'b0;

    // first-voice response to a step
    scen1_config();
    pulse();
    repeat (3) @(negedge clk);
    check("s1_hp0", hp_of(0), 64);
    check("s1_bp0", bp_of(0), 7);
    check("s1_lp0", lp_of(0), 0);
    wait_done();
    check("s1_bp_state", int'(dut.bp_st[0]), 16'sh07FF);
    check("s1_lp_state", int'(dut.lp_st[0]), 16'sh00FF);

    // alpha1 = 0 passes input straight to hp, frame length 9
    do_reset();
    set_voice(0, 100, 0, 3);
    set_voice(1, -50, 0, 2);
    set_voice(2, 5, 0, 1);
    for (int fr = 0; fr < 3; fr++) begin
      pulse();
      repeat (8) @(negedge clk);
      check("s2_done_early", int'(bus.frame_done), 0);
      @(negedge clk);
      check("s2_done_at9", int'(bus.frame_done), 1);
      check("s2_hp0", hp_of(0), 100);
      check("s2_hp1", hp_of(1), -50);
      check("s2_hp2", hp_of(2), 5);
      check("s2_bp1", bp_of(1), 0);
      check("s2_lp2", lp_of(2), 0);
    end

    // long settling at full scale, both polarities
    do_reset();
    set_voice(0, 0, 0, 0);
    set_voice(1, 127, 2047, 3);
    set_voice(2, 0, 0, 0);
    for (int fr = 0; fr < 200; fr++) begin
      pulse();
      wait_done();
    end
    check("s3_lp_pos", int'(lp_of(1) >= 118), 1);
    set_voice(1, -128, 2047, 3);
    for (int fr = 0; fr < 200; fr++) begin
      pulse();
      wait_done();
    end
    check("s3_lp_neg", int'(lp_of(1) <= -118), 1);

    // negative full scale on voice 2 only
    do_reset();
    set_voice(0, 0, 1000, 3);
    set_voice(1, 0, 500, 1);
    set_voice(2, -128, 2047, 0);
    pulse();
    wait_done();
    check("s4_hp2", hp_of(2), -128);
    check("s4_bp2", bp_of(2), -16);
    check("s4_bp_state2", int'(dut.bp_st[2]), -4094);
    check("s4_hp0", hp_of(0), 0);
    check("s4_lp1", lp_of(1), 0);

    // overrun on a second request mid-frame
    do_reset();
    scen1_config();
    pulse();
    set_voice(0, 10, 100, 1);
    repeat (3) @(negedge clk);
    pulse();
    check("s5_ovr_hi", int'(bus.overrun), 1);
    @(negedge clk);
    check("s5_ovr_lo", int'(bus.overrun), 0);
    begin
      int nd = 0;
      for (int c = 0; c < 10; c++) begin
        if (bus.frame_done) nd++;
        @(negedge clk);
      end
      check("s5_single_done", nd, 1);
    end
    check("s5_hp0", hp_of(0), 64);
    check("s5_bp0", bp_of(0), 7);

    // reset in the middle of a frame
    do_reset();
    scen1_config();
    pulse();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("s6_hp0_zero", hp_of(0), 0);
    check("s6_busy_zero", int'(bus.busy), 0);
    check("s6_state_zero", int'(dut.bp_st[0]), 0);
    rst = 1'b0;
    pulse();
    wait_done();
    check("s6_hp0", hp_of(0), 64);
    check("s6_bp0", bp_of(0), 7);
    check("s6_lp0", lp_of(0), 0);

    // new request on the frame_done cycle is accepted
    pulse();
    wait_done();
    pulse();
    check("s7_busy_again", int'(bus.busy), 1);
    wait_done();

    // randomized traffic, checked by the cycle model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int v = 0; v < N; v++)
          set_voice(v, int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 2047)),
                    int'($urandom_range(0, 3)));
      end
      bus.sample_valid = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    bus.sample_valid = 1'b0;
    rst = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
